// File: rtl/regfile_fwd.sv
// regfile_fwd: two-read/one-write register file with registered read ports,
// same-cycle write-to-read forwarding and a hardwired zero register.
// Port B reads rc or rb (ra2sel); the write address is rc or xp_reg (wasel).
// Optional macro REGFILE_SCOREBOARD_EN adds a per-register pending-write
// scoreboard driving busy_a/busy_b; without it those outputs are tied to 0.
module regfile_fwd #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    input  logic [ADDR_W-1:0] rc,
    input  logic              ra2sel,
    input  logic [ADDR_W-1:0] xp_reg,
    input  logic              wasel,
    input  logic              werf,
    input  logic [DATA_W-1:0] wd,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rc,
    output logic              busy_a,
    output logic              busy_b
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [ADDR_W-1:0] wa;
    logic [ADDR_W-1:0] rb_sel;
    logic              wr_en;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] val_a;
    logic [DATA_W-1:0] val_b;

    assign wa     = wasel  ? xp_reg : rc;
    assign rb_sel = ra2sel ? rc     : rb;
    // The zero register never takes a write, so its storage stays at reset 0.
    assign wr_en  = werf && (wa != ZERO_ADDR);

    // Storage: cleared by reset, written on the rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wa] <= wd;
        end
    end

    // Port A read value: zero register first, then the in-flight write, then storage.
    always_comb begin
        val_a = mem[ra];
        if (ra == ZERO_ADDR) begin
            val_a = '0;
        end else if (werf && (wa == ra)) begin
            val_a = wd;
        end
    end

    // Port B read value, same priority as port A.
    always_comb begin
        val_b = mem[rb_sel];
        if (rb_sel == ZERO_ADDR) begin
            val_b = '0;
        end else if (werf && (wa == rb_sel)) begin
            val_b = wd;
        end
    end

    // Registered read outputs; hold when rd_en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd1 <= '0;
            rd2 <= '0;
        end else if (rd_en) begin
            rd1 <= val_a;
            rd2 <= val_b;
        end
    end

`ifdef REGFILE_SCOREBOARD_EN
    logic [DEPTH-1:0] sb;

    // Scoreboard: a write clears the pending bit, a new issue sets it; the
    // issue is applied last so a newer producer wins on a same-edge collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (werf && (wa == ADDR_W'(i))) begin
                    sb[i] <= 1'b0;
                end
                if (issue_valid && (issue_rc == ADDR_W'(i)) && (issue_rc != ZERO_ADDR)) begin
                    sb[i] <= 1'b1;
                end
            end
        end
    end

    assign busy_a = sb[ra]     && (ra     != ZERO_ADDR);
    assign busy_b = sb[rb_sel] && (rb_sel != ZERO_ADDR);
`else
    logic unused_issue;
    assign unused_issue = ^{issue_valid, issue_rc};
    assign busy_a = 1'b0;
    assign busy_b = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_fwd.sv
// Testbench for regfile_fwd: directed scenarios plus randomized traffic checked
// against an array-based behavioural model of the register file.
module tb_regfile_fwd;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  ra, rb, rc, xp_reg, issue_rc;
    logic        ra2sel, wasel, werf, rd_en, issue_valid;
    logic [31:0] wd;
    logic [31:0] rd1, rd2;
    logic        busy_a, busy_b;

    int checks   = 0;
    int failures = 0;

    // Behavioural model
    logic [31:0] m_mem [32];
    bit          m_sb  [32];
    logic [31:0] exp_rd1, exp_rd2;

    regfile_fwd #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(31)) dut (
        .clk(clk), .rst_n(rst_n), .ra(ra), .rb(rb), .rc(rc), .ra2sel(ra2sel),
        .xp_reg(xp_reg), .wasel(wasel), .werf(werf), .wd(wd), .rd_en(rd_en),
        .rd1(rd1), .rd2(rd2), .issue_valid(issue_valid), .issue_rc(issue_rc),
        .busy_a(busy_a), .busy_b(busy_b)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] m_wa();
        return wasel ? xp_reg : rc;
    endfunction

    function automatic logic [4:0] m_rbsel();
        return ra2sel ? rc : rb;
    endfunction

    function automatic logic [31:0] m_val(input logic [4:0] x);
        if (x == 5'd31) return 32'h0;
        if (werf && (m_wa() == x)) return wd;
        return m_mem[x];
    endfunction

    function automatic logic m_busy(input logic [4:0] x);
`ifdef REGFILE_SCOREBOARD_EN
        return (x != 5'd31) && m_sb[x];
`else
        return 1'b0;
`endif
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i] = 32'h0;
            m_sb[i]  = 1'b0;
        end
        exp_rd1 = 32'h0;
        exp_rd2 = 32'h0;
    endtask

    task automatic idle();
        ra = 0; rb = 0; rc = 0; xp_reg = 0; issue_rc = 0;
        ra2sel = 0; wasel = 0; werf = 0; rd_en = 1; issue_valid = 0; wd = 0;
    endtask

    // One clock edge: advance the model with the current inputs, then wait
    // until just after the edge.
    task automatic step();
        logic [31:0] na, nb;
        logic [4:0]  w;
        na = m_val(ra);
        nb = m_val(m_rbsel());
        w  = m_wa();
        if (werf && w != 5'd31) m_mem[w] = wd;
        if (werf) m_sb[w] = 1'b0;
        if (issue_valid && issue_rc != 5'd31) m_sb[issue_rc] = 1'b1;
        if (rd_en) begin
            exp_rd1 = na;
            exp_rd2 = nb;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        werf = 1; rc = 5'd3; wd = 32'h1234;
        rst_n = 0;
        m_reset();
        #3;
        ra = 5'd3; rb = 5'd7; ra2sel = 0; rd_en = 1;
        @(posedge clk); #1;
        checks++;
        if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
            failures++;
            $display("FAIL reset_hold rd1=%h rd2=%h required 0/0", rd1, rd2);
        end
        checks++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy busy_a=%b busy_b=%b required 0/0", busy_a, busy_b);
        end
        werf = 0;
        rst_n = 1;
        #1;
        step();
        checks++;
        if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
            failures++;
            $display("FAIL reset_read rd1=%h rd2=%h required 0/0", rd1, rd2);
        end
        $display("test_reset: rd1=%h rd2=%h", rd1, rd2);
    endtask

    task automatic test_write_read();
        idle();
        werf = 1; wasel = 0; rc = 5'd5; wd = 32'hDEADBEEF;
        step();
        idle();
        ra = 5'd5;
        step();
        checks++;
        if (rd1 !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL write_read rd1=%h required %h", rd1, 32'hDEADBEEF);
        end
        $display("test_write_read: rd1=%h", rd1);
    endtask

    task automatic test_forwarding();
        idle();
        werf = 1; rc = 5'd9; wd = 32'h11;
        step();
        idle();
        werf = 1; rc = 5'd9; wd = 32'h22; ra = 5'd9; rb = 5'd9; ra2sel = 0;
        step();
        checks++;
        if (rd1 !== 32'h22) begin
            failures++;
            $display("FAIL fwd_a rd1=%h required %h", rd1, 32'h22);
        end
        checks++;
        if (rd2 !== 32'h22) begin
            failures++;
            $display("FAIL fwd_b rd2=%h required %h", rd2, 32'h22);
        end
        $display("test_forwarding: rd1=%h rd2=%h", rd1, rd2);
    endtask

    task automatic test_zero_reg();
        idle();
        werf = 1; rc = 5'd31; wd = 32'hFFFF_FFFF; ra = 5'd31; ra2sel = 1;
        step();
        checks++;
        if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
            failures++;
            $display("FAIL zero_fwd rd1=%h rd2=%h required 0/0", rd1, rd2);
        end
        werf = 0;
        step();
        checks++;
        if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
            failures++;
            $display("FAIL zero_read rd1=%h rd2=%h required 0/0", rd1, rd2);
        end
        $display("test_zero_reg: rd1=%h rd2=%h", rd1, rd2);
    endtask

    task automatic test_xp_portb();
        idle();
        werf = 1; rc = 5'd4; wd = 32'h44;
        step();
        idle();
        werf = 1; wasel = 1; xp_reg = 5'd30; rc = 5'd4; wd = 32'hA5;
        step();
        idle();
        ra2sel = 1; rc = 5'd30; rb = 5'd4; ra = 5'd4;
        step();
        checks++;
        if (rd2 !== 32'hA5) begin
            failures++;
            $display("FAIL xp_portb rd2=%h required %h", rd2, 32'hA5);
        end
        checks++;
        if (rd1 !== 32'h44) begin
            failures++;
            $display("FAIL xp_rc_untouched rd1=%h required %h", rd1, 32'h44);
        end
        $display("test_xp_portb: rd1=%h rd2=%h", rd1, rd2);
    endtask

    task automatic test_rd_hold();
        idle();
        rd_en = 0; ra = 5'd5; rb = 5'd30;
        step();
        checks++;
        if (rd1 !== exp_rd1 || rd2 !== exp_rd2) begin
            failures++;
            $display("FAIL rd_hold rd1=%h rd2=%h required %h/%h", rd1, rd2, exp_rd1, exp_rd2);
        end
        $display("test_rd_hold: rd1=%h rd2=%h", rd1, rd2);
    endtask

    task automatic test_scoreboard();
        idle();
        issue_valid = 1; issue_rc = 5'd12;
        step();
        idle();
        ra = 5'd12;
        #1;
        checks++;
        if (busy_a !== m_busy(5'd12)) begin
            failures++;
            $display("FAIL sb_set busy_a=%b required %b", busy_a, m_busy(5'd12));
        end
        werf = 1; rc = 5'd12; wd = 32'h77; issue_valid = 1; issue_rc = 5'd12;
        step();
        idle();
        ra = 5'd12;
        #1;
        checks++;
        if (busy_a !== m_busy(5'd12)) begin
            failures++;
            $display("FAIL sb_set_wins busy_a=%b required %b", busy_a, m_busy(5'd12));
        end
        werf = 1; rc = 5'd12; wd = 32'h78;
        step();
        idle();
        ra = 5'd12;
        #1;
        checks++;
        if (busy_a !== 1'b0) begin
            failures++;
            $display("FAIL sb_clear busy_a=%b required 0", busy_a);
        end
        $display("test_scoreboard: busy_a=%b", busy_a);
    endtask

    task automatic test_random();
        int bad;
        for (int n = 0; n < 300; n++) begin
            ra     = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(24, 31));
            rb     = 5'($urandom_range(24, 31));
            rc     = 5'($urandom_range(24, 31));
            xp_reg = 5'($urandom_range(24, 31));
            ra2sel = 1'($urandom);
            wasel  = 1'($urandom);
            werf   = 1'($urandom);
            wd     = $urandom;
            rd_en  = ($urandom_range(0, 4) != 0);
            issue_valid = 1'($urandom);
            issue_rc    = 5'($urandom_range(24, 31));
            #1;
            bad = 0;
            checks++;
            if (busy_a !== m_busy(ra) || busy_b !== m_busy(m_rbsel())) begin
                failures++; bad = 1;
                $display("FAIL rand_busy n=%0d busy_a=%b busy_b=%b required %b/%b",
                         n, busy_a, busy_b, m_busy(ra), m_busy(m_rbsel()));
            end
            step();
            checks++;
            if (rd1 !== exp_rd1 || rd2 !== exp_rd2) begin
                failures++; bad = 1;
                $display("FAIL rand_read n=%0d rd1=%h rd2=%h required %h/%h",
                         n, rd1, rd2, exp_rd1, exp_rd2);
            end
            if (bad == 0 && (n % 50) == 0)
                $display("test_random n=%0d rd1=%h rd2=%h", n, rd1, rd2);
        end
    endtask

    task automatic test_reset_midop();
        idle();
        werf = 1; rc = 5'd6; wd = 32'hCAFE;
        step();
        // Reset asserted mid-cycle with a write pending; the write is lost.
        idle();
        werf = 1; rc = 5'd7; wd = 32'hBEEF;
        #2;
        rst_n = 0;
        m_reset();
        @(posedge clk); #1;
        rst_n = 1;
        idle();
        ra = 5'd6; rb = 5'd7;
        step();
        checks++;
        if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
            failures++;
            $display("FAIL reset_midop rd1=%h rd2=%h required 0/0", rd1, rd2);
        end
        $display("test_reset_midop: rd1=%h rd2=%h", rd1, rd2);
    endtask

    initial begin
        rst_n = 1;
        idle();
        m_reset();
        @(posedge clk); #1;
        test_reset();
        test_write_read();
        test_forwarding();
        test_zero_reg();
        test_xp_portb();
        test_rd_hold();
        test_scoreboard();
        test_random();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_fwd.md
Name: regfile_fwd

Overview:
- Parametrised two-read/one-write register file for the Beta-style datapath; next generation of the current regfile wrapper.
- Adds registered read outputs, write-to-read forwarding, a hardwired zero register and async active-low reset of the storage.
- Keeps the RA2SEL (Rb/Rc) and WASEL (Rc/XP) address muxing.
- Sits between decode (addresses in) and the ALU operand muxes (RD1/RD2 out).

Parameters:
- DATA_W, 32, data width of each register and of WD/RD1/RD2.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.
- ZERO_REG, 31, index of the register that always reads 0 and ignores writes.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ra  input  ADDR_W  read address A.
- rb  input  ADDR_W  read address B candidate.
- rc  input  ADDR_W  Rc field; read address B candidate and write address candidate.
- ra2sel  input  1  1: port B reads rc; 0: port B reads rb.
- xp_reg  input  ADDR_W  exception/link write address.
- wasel  input  1  1: write address = xp_reg; 0: write address = rc.
- werf  input  1  write enable.
- wd  input  DATA_W  write data.
- rd_en  input  1  read enable; when 0, rd1/rd2 hold their values.
- rd1  output  DATA_W  registered read data A.
- rd2  output  DATA_W  registered read data B.
- issue_valid  input  1  scoreboard: an instruction is issued that will write issue_rc.
- issue_rc  input  ADDR_W  scoreboard: destination of the issued instruction.
- busy_a  output  1  scoreboard: the current port A address has a pending write.
- busy_b  output  1  scoreboard: the current port B address has a pending write.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All 2**ADDR_W registers clear to 0.
  - rd1 = 0, rd2 = 0.
  - Scoreboard bits clear, so busy_a = busy_b = 0.
  - Reset asserted mid-operation discards any write in that cycle; the first post-reset edge behaves normally.
- Address muxing (combinational):
  - wa = wasel ? xp_reg : rc.
  - rb_sel = ra2sel ? rc : rb.
  - Muxing uses no delay constructs.
- Write: at the rising edge, if werf = 1 and wa != ZERO_REG, then mem[wa] <= wd.
  - Writes to ZERO_REG are silently dropped.
- Read:
  - At the rising edge with rd_en = 1: rd1 <= val(ra) and rd2 <= val(rb_sel).
  - One-cycle latency: addresses presented in cycle N give data valid after edge N+1.
  - rd_en = 0: rd1/rd2 hold.
- val(x), in priority order:
  1. If x == ZERO_REG, the value is 0 (overrides forwarding).
  2. Else, if werf = 1 and wa == x, the value is wd (same-cycle write forwarded; the read never sees stale data).
  3. Else, the value is mem[x].
- Both ports may read the same address; both get an identical value.
- Address wrap: addresses are exactly ADDR_W bits; no out-of-range case exists.
- Scoreboard (when compiled in): one bit per register.
  - Set on the edge where issue_valid = 1 and issue_rc != ZERO_REG.
  - Cleared on the edge where werf = 1 and wa matches.
  - Simultaneous set and clear of the same index: set wins (a newer producer is pending).
  - busy_a = sb[ra]; busy_b = sb[rb_sel]. Both are combinational from current addresses and state.
  - busy_* is always 0 for ZERO_REG.

Optional Feature:
- Macro REGFILE_SCOREBOARD_EN.
- Defined: the scoreboard exists as described; issue_valid and issue_rc are functional; busy_a/busy_b are driven.
- Undefined:
  - No scoreboard flops.
  - issue_valid and issue_rc are ignored.
  - busy_a and busy_b are tied to 0.
  - Ports remain present so the interface is identical in both builds.

Test Plan:
- Reset then read: rst_n low, ra=3, ra2sel=0, rb=7, rd_en=1 -> after release and one edge, rd1 = 0 and rd2 = 0.
- Write then read: werf=1, wasel=0, rc=5, wd=32'hDEADBEEF for one edge; next cycle ra=5 -> rd1 = 32'hDEADBEEF one edge later.
- Forwarding: mem[9]=32'h11; same cycle werf=1, rc=9, wd=32'h22, ra=9 -> rd1 = 32'h22 after that edge, not 32'h11.
- Zero register: werf=1, rc=31, wd=32'hFFFF_FFFF; then ra=31 and ra2sel=1 with rc=31 -> rd1 = 0 and rd2 = 0, including in the same-cycle forwarding case.
- XP write and port-B select:
  - wasel=1, xp_reg=30, rc=4, wd=32'hA5 -> mem[30]=32'hA5 and mem[4] unchanged.
  - Then ra2sel=1, rc=30, rb=4 -> rd2 = 32'hA5.
- Scoreboard (REGFILE_SCOREBOARD_EN): issue_valid=1, issue_rc=12 -> busy_a=1 while ra=12.
  - Write rc=12 with issue_valid=1, issue_rc=12 on the same edge -> busy stays 1.
  - A later lone write to 12 -> busy_a = 0.
  - Build without the macro -> busy_a = 0 throughout.
